// File: rtl/freq_meter_poller.sv
// AXI4-Lite master that configures a bank of frequency meters with a common
// gate select and then round-robin polls their status registers.
module freq_meter_poller #(
    parameter int N_METERS    = 4,
    parameter int POLL_CYCLES = 200000,
    localparam int IDX_W      = (N_METERS > 1) ? $clog2(N_METERS) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    enable,
    input  logic [1:0]              gate_sel,
    input  logic [15:0]             thr_lo,
    input  logic [15:0]             thr_hi,
    input  logic                    err_clr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [12+IDX_W-1:0]     m_awaddr,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [31:0]             m_wdata,
    output logic [3:0]              m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [12+IDX_W-1:0]     m_araddr,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [31:0]             m_rdata,
    input  logic [1:0]              m_rresp,
    output logic [16*N_METERS-1:0]  meas_cnt,
    output logic [N_METERS-1:0]     meas_ovf,
    output logic [N_METERS-1:0]     meas_valid,
    output logic [N_METERS-1:0]     alarm,
    output logic [N_METERS-1:0]     upd_pulse,
    output logic                    err,
    output logic                    busy
);

    localparam int CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CFG_REQ, CFG_RSP, WAIT, RD_REQ, RD_RSP} state_t;

    // Current FSM state; left as a named enum so checkers can bind to it.
    state_t state, state_nxt;

    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       applied_sel;
    logic             aw_done, w_done;
    logic             aw_hs, w_hs, cfg_sent, last_idx, err_set, rd_ok;
    logic [15:0]      rd_cnt;
    logic             unused_rdata;

    // Valid/ready: a transfer happens on the aclk edge where both are high.
    // Valids are held with a stable payload until that edge and never depend
    // combinationally on ready; each channel completes independently.
    assign aw_hs    = m_awvalid & m_awready;
    assign w_hs     = m_wvalid & m_wready;
    assign cfg_sent = (aw_done | aw_hs) & (w_done | w_hs);
    assign last_idx = (idx == IDX_W'(N_METERS - 1));
    assign err_set  = (m_bready & m_bvalid & (m_bresp != 2'b00)) |
                      (m_rready & m_rvalid & (m_rresp != 2'b00));
    assign rd_ok    = (m_rresp == 2'b00) & m_rdata[17];
    assign rd_cnt   = m_rdata[15:0];
    assign unused_rdata = ^m_rdata[31:18];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = CFG_REQ;
            CFG_REQ: if (cfg_sent) state_nxt = CFG_RSP;
            CFG_RSP: if (m_bvalid) begin
                if (!enable)      state_nxt = IDLE;
                else if (last_idx) state_nxt = WAIT;
                else              state_nxt = CFG_REQ;
            end
            WAIT: begin
                if (!enable)                     state_nxt = IDLE;
                else if (gate_sel != applied_sel) state_nxt = CFG_REQ;
                else if (cnt == '0)              state_nxt = RD_REQ;
            end
            RD_REQ:  if (m_arready) state_nxt = RD_RSP;
            RD_RSP:  if (m_rvalid) begin
                if (!enable)      state_nxt = IDLE;
                else if (last_idx) state_nxt = WAIT;
                else              state_nxt = RD_REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_awvalid = (state == CFG_REQ) & ~aw_done;
        m_wvalid  = (state == CFG_REQ) & ~w_done;
        m_awaddr  = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_araddr  = '0;
        if (state == CFG_REQ) begin
            m_awaddr = {idx, 12'h004};
            m_wdata  = {30'b0, applied_sel};
            m_wstrb  = 4'hF;
        end
        if (state == RD_REQ) m_araddr = {idx, 12'h008};
        m_bready  = (state == CFG_RSP);
        m_arvalid = (state == RD_REQ);
        m_rready  = (state == RD_RSP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx         <= '0;
            cnt         <= '0;
            applied_sel <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            meas_cnt    <= '0;
            meas_ovf    <= '0;
            meas_valid  <= '0;
            alarm       <= '0;
            upd_pulse   <= '0;
            err         <= 1'b0;
        end else begin
            upd_pulse <= '0;
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    applied_sel <= gate_sel;
                    idx         <= '0;
                end
                CFG_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if (cfg_sent) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                CFG_RSP: if (m_bvalid && enable) begin
                    if (last_idx) cnt <= CNT_RELOAD;
                    else          idx <= idx + IDX_W'(1);
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    // A new gate select invalidates results and forces a full reconfigure.
                    if (enable && gate_sel != applied_sel) begin
                        meas_valid  <= '0;
                        applied_sel <= gate_sel;
                        idx         <= '0;
                    end else if (cnt == '0) begin
                        idx <= '0;
                    end
                end
                RD_RSP: if (m_rvalid) begin
                    if (rd_ok) begin
                        meas_cnt[16*idx +: 16] <= rd_cnt;
                        meas_ovf[idx]          <= m_rdata[16];
                        meas_valid[idx]        <= 1'b1;
                        upd_pulse[idx]         <= 1'b1;
                        alarm[idx]             <= m_rdata[16] | (rd_cnt < thr_lo) | (rd_cnt > thr_hi);
                    end
                    if (enable) begin
                        if (last_idx) cnt <= CNT_RELOAD;
                        else          idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter_poller.sv
// Bench for freq_meter_poller: two meters behind a scripted AXI4-Lite slave,
// with a transaction scoreboard and direct checks on the result registers.
module tb_freq_meter_poller;

    localparam int N = 2;
    localparam int P = 10;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  gate_sel = 2'd2;
    logic [15:0] thr_lo = 16'd100;
    logic [15:0] thr_hi = 16'd300;
    logic        err_clr = 1'b0;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [12:0] m_awaddr, m_araddr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic [16*N-1:0] meas_cnt;
    logic [N-1:0] meas_ovf, meas_valid, alarm, upd_pulse;
    logic        err, busy;

    always #5 aclk = ~aclk;

    freq_meter_poller #(.N_METERS(N), .POLL_CYCLES(P)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .gate_sel(gate_sel),
        .thr_lo(thr_lo), .thr_hi(thr_hi), .err_clr(err_clr),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .meas_cnt(meas_cnt), .meas_ovf(meas_ovf), .meas_valid(meas_valid),
        .alarm(alarm), .upd_pulse(upd_pulse), .err(err), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [47:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] tr(input logic [2:0] k, input logic [12:0] a, input logic [31:0] d);
        return {k, a, d};
    endfunction

    task automatic sb_pop(input string tag, input logic [47:0] obs);
        if (exp_q.size() == 0) check_eq({tag, "_unexpected"}, 64'(exp_q.size()), 64'd1);
        else                   check_eq(tag, obs, exp_q.pop_front());
    endtask

    // slave model configuration and observation
    int          aw_stall = 0, r_stall = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_m[N];
    int          cyc = 0, aw_cnt = 0, aw_high = 0, w_high = 0, last_aw_high = 0, last_w_high = 0;
    int          b_cnt = 0, r_cnt = 0, r_wait = 0, last_b_cyc = 0, first_ar_cyc = 0;
    int          upd_cnt[N];
    bit          aw_got, w_got, b_due, b_fire, r_pend, r_fire, ar_first_pending;
    bit          prev_aw_wait, prev_w_wait;
    logic [12:0] cap_awaddr, prev_awaddr;
    logic [31:0] cap_wdata, prev_wdata;
    logic        r_sel;

    initial begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        for (int i = 0; i < N; i++) begin upd_cnt[i] = 0; rdata_m[i] = 0; end
        forever begin
            @(negedge aclk);
            cyc++;
            if (!aresetn) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
                aw_got = 0; w_got = 0; b_due = 0; b_fire = 0; r_pend = 0; r_fire = 0;
                prev_aw_wait = 0; prev_w_wait = 0; aw_cnt = 0; aw_high = 0; w_high = 0;
                continue;
            end
            for (int i = 0; i < N; i++) if (upd_pulse[i]) upd_cnt[i]++;
            if (prev_aw_wait) check_eq("aw_hold", {m_awvalid, m_awaddr}, {1'b1, prev_awaddr});
            if (prev_w_wait)  check_eq("w_hold", {m_wvalid, m_wdata}, {1'b1, prev_wdata});
            if (b_fire) begin m_bvalid = 0; b_fire = 0; end
            if (r_fire) begin m_rvalid = 0; r_fire = 0; end
            if (b_due) begin m_bvalid = 1; m_bresp = bresp_cfg; b_due = 0; end
            if (r_pend) begin
                if (r_wait == 0) begin
                    m_rvalid = 1; m_rdata = rdata_m[r_sel]; m_rresp = rresp_cfg; r_pend = 0;
                end else r_wait--;
            end
            if (m_awvalid) begin
                aw_high++;
                m_awready = (aw_cnt >= aw_stall);
                aw_cnt++;
                if (m_awready) begin
                    cap_awaddr = m_awaddr; aw_got = 1; last_aw_high = aw_high; aw_high = 0; aw_cnt = 0;
                end
            end else begin
                m_awready = 0; aw_cnt = 0; aw_high = 0;
            end
            if (m_wvalid) begin
                w_high++;
                m_wready = 1;
                cap_wdata = m_wdata; w_got = 1; last_w_high = w_high; w_high = 0;
                check_eq("wstrb", m_wstrb, 4'hF);
            end else begin
                m_wready = 0; w_high = 0;
            end
            if (aw_got && w_got) begin
                sb_pop("write", tr(3'd1, cap_awaddr, cap_wdata));
                aw_got = 0; w_got = 0; b_due = 1;
            end
            if (m_arvalid) begin
                m_arready = 1;
                sb_pop("read", tr(3'd2, m_araddr, 32'd0));
                r_sel = m_araddr[12]; r_pend = 1; r_wait = r_stall;
                if (ar_first_pending) begin first_ar_cyc = cyc; ar_first_pending = 0; end
            end else m_arready = 0;
            if (m_bvalid && m_bready) begin
                b_fire = 1; b_cnt++; last_b_cyc = cyc; ar_first_pending = 1;
            end
            if (m_rvalid && m_rready) begin r_fire = 1; r_cnt++; end
            prev_aw_wait = m_awvalid && !m_awready; prev_awaddr = m_awaddr;
            prev_w_wait  = m_wvalid && !m_wready;   prev_wdata  = m_wdata;
        end
    end

    task automatic wait_reads(input int target);
        int t = 0;
        while (r_cnt < target && t < 500) begin @(negedge aclk); t++; end
        check_eq("reads_done", 64'(r_cnt >= target), 64'd1);
        repeat (3) @(negedge aclk);
    endtask

    task automatic push_reads();
        exp_q.push_back(tr(3'd2, 13'h0008, 32'd0));
        exp_q.push_back(tr(3'd2, 13'h1008, 32'd0));
    endtask

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog obs=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        int b_base, r_base, t;
        repeat (3) @(negedge aclk);
        check_eq("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
        check_eq("rst_addr", {m_awaddr, m_araddr, m_wdata, m_wstrb}, '0);
        check_eq("rst_meas", {meas_cnt, meas_ovf, meas_valid, alarm, upd_pulse}, '0);
        check_eq("rst_err_busy", {err, busy}, 2'b00);
        aresetn = 1;
        @(negedge aclk);

        // sweep 1: configure both meters with gate 2, then poll
        rdata_m[0] = 32'h0002_0064;
        rdata_m[1] = 32'h0002_00C8;
        exp_q.push_back(tr(3'd1, 13'h0004, 32'd2));
        exp_q.push_back(tr(3'd1, 13'h1004, 32'd2));
        push_reads();
        enable = 1;
        wait_reads(2);
        check_eq("wait_gap", 64'(first_ar_cyc - last_b_cyc - 1), 64'(P));
        check_eq("s1_cnt", meas_cnt, {16'd200, 16'd100});
        check_eq("s1_ovf_alarm", {meas_ovf, alarm}, 4'b0000);
        check_eq("s1_valid", meas_valid, 2'b11);
        check_eq("s1_upd", {upd_cnt[1][7:0], upd_cnt[0][7:0]}, {8'd1, 8'd1});

        // sweep 2: overflowed meter1, upper threshold is inclusive
        rdata_m[0] = 32'h0002_012C;
        rdata_m[1] = 32'h0003_FFFF;
        push_reads();
        wait_reads(4);
        check_eq("s2_cnt", meas_cnt, {16'hFFFF, 16'd300});
        check_eq("s2_ovf", meas_ovf, 2'b10);
        check_eq("s2_alarm", alarm, 2'b10);

        // sweep 3: meter1 not updated, meter0 below range
        rdata_m[0] = 32'h0002_0063;
        rdata_m[1] = 32'h0000_0010;
        push_reads();
        wait_reads(6);
        check_eq("s3_cnt", meas_cnt, {16'hFFFF, 16'd99});
        check_eq("s3_ovf_alarm", {meas_ovf, alarm}, 4'b1011);
        check_eq("s3_upd", {upd_cnt[1][7:0], upd_cnt[0][7:0]}, {8'd2, 8'd3});

        // sweep 4: inverted thresholds alarm on every update
        thr_lo = 16'd500; thr_hi = 16'd400;
        rdata_m[0] = 32'h0002_01C2;
        rdata_m[1] = 32'h0002_0064;
        push_reads();
        wait_reads(8);
        check_eq("s4_cnt", meas_cnt, {16'd100, 16'd450});
        check_eq("s4_ovf_alarm", {meas_ovf, alarm}, 4'b0011);
        thr_lo = 16'd100; thr_hi = 16'd300;

        // sweep 5: error responses leave results alone
        rresp_cfg = 2'b10;
        rdata_m[0] = 32'h0002_0001;
        rdata_m[1] = 32'h0002_0001;
        push_reads();
        wait_reads(10);
        check_eq("s5_err", err, 1'b1);
        check_eq("s5_cnt", meas_cnt, {16'd100, 16'd450});
        check_eq("s5_alarm_valid", {alarm, meas_valid}, 4'b1111);
        check_eq("s5_upd", {upd_cnt[1][7:0], upd_cnt[0][7:0]}, {8'd3, 8'd4});
        rresp_cfg = 2'b00;
        err_clr = 1;
        @(negedge aclk);
        err_clr = 0;
        check_eq("err_clr", err, 1'b0);

        // gate change during the wait, with a stalled write-address channel
        aw_stall = 4;
        b_base = b_cnt;
        rdata_m[0] = 32'h0002_00C8;
        rdata_m[1] = 32'h0002_0096;
        exp_q.push_back(tr(3'd1, 13'h0004, 32'd1));
        exp_q.push_back(tr(3'd1, 13'h1004, 32'd1));
        push_reads();
        gate_sel = 2'd1;
        @(negedge aclk);
        check_eq("gate_inval", meas_valid, 2'b00);
        wait_reads(12);
        check_eq("aw_held", 64'(last_aw_high), 64'd5);
        check_eq("w_once", 64'(last_w_high), 64'd1);
        check_eq("b_count", 64'(b_cnt - b_base), 64'd2);
        check_eq("s6_cnt", meas_cnt, {16'd150, 16'd200});
        check_eq("s6_valid_alarm", {meas_valid, alarm}, 4'b1100);
        aw_stall = 0;

        // drop enable while a read response is pending
        r_stall = 3;
        r_base = r_cnt;
        rdata_m[0] = 32'h0002_0070;
        exp_q.push_back(tr(3'd2, 13'h0008, 32'd0));
        t = 0;
        while (!m_rready && t < 100) begin @(negedge aclk); t++; end
        check_eq("rd_rsp_seen", m_rready, 1'b1);
        enable = 0;
        wait_reads(r_base + 1);
        repeat (15) @(negedge aclk);
        check_eq("dis_reads", 64'(r_cnt - r_base), 64'd1);
        check_eq("dis_busy", busy, 1'b0);
        check_eq("dis_result", {meas_cnt[15:0], meas_valid}, {16'd112, 2'b11});
        check_eq("dis_sb_empty", 64'(exp_q.size()), 64'd0);
        r_stall = 0;

        // re-enable reconfigures; reset in the middle of the write
        aw_stall = 8;
        enable = 1;
        t = 0;
        while (!m_awvalid && t < 50) begin @(negedge aclk); t++; end
        check_eq("recfg_aw", {m_awvalid, m_awaddr, m_wdata}, {1'b1, 13'h0004, 32'd1});
        repeat (2) @(negedge aclk);
        check_eq("recfg_stall", m_awvalid, 1'b1);
        #2 aresetn = 0;
        #1;
        check_eq("arst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
        check_eq("arst_state", {busy, err, meas_valid}, 4'b0);
        check_eq("arst_meas", meas_cnt, '0);
        enable = 0;
        aw_stall = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1;
        repeat (2) @(negedge aclk);
        check_eq("final_idle", {busy, m_awvalid}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
